fp16_mul_arbiter: RTL and testbench

//  Round-robin arbiter and 2-stage pipeline that shares one combinational fp16 (half-precision) multiplier between

---
 rtl/fp16_mul_arbiter_pkg.sv | 22 ++
 rtl/fp16_mul_arbiter_if.sv | 31 +++
 rtl/fp16_mul_arbiter_mul.sv | 43 ++++
 rtl/fp16_mul_arbiter_rr.sv | 29 ++
 rtl/fp16_mul_arbiter.sv | 133 +++++++++++++
 tb/tb_fp16_mul_arbiter.sv | 243 ++++++++++++++++++++++++
 6 files changed

// File: rtl/fp16_mul_arbiter_pkg.sv
// rtl/fp16_mul_arbiter_pkg.sv - fp16 constants and the operand-beat type shared by the arbiter slice
package fp16_pkg;

  localparam int FP16_W     = 16;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP16_BIAS  = 15;

  localparam logic [FP16_W-1:0] FP16_ZERO  = 16'h0000;
  localparam logic [FP16_W-1:0] FP16_NZERO = 16'h8000;

  // Requester-ID field width carried in the operand beat; wide enough for any sensible NREQ
  localparam int OP_ID_W = 8;

  // One accepted operand pair plus the index of the requester that supplied it
  typedef struct packed {
    logic [FP16_W-1:0]  a;
    logic [FP16_W-1:0]  b;
    logic [OP_ID_W-1:0] id;
  } op_beat_t;

endpackage

// File: rtl/fp16_mul_arbiter_if.sv
// rtl/fp16_mul_arbiter_if.sv - requester and result channels between the spin-update engines and the arbiter
interface fp16_mul_arbiter_if
  import fp16_pkg::*;
#(
  parameter int NREQ = 4
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [FP16_W*NREQ-1:0] req_a;
  logic [FP16_W*NREQ-1:0] req_b;

  logic                   res_valid;
  logic                   res_ready;
  logic [FP16_W-1:0]      res_data;
  logic [ID_W-1:0]        res_id;

  // Requesters and the result consumer
  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  // The arbiter/pipeline
  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );

endinterface

// File: rtl/fp16_mul_arbiter_mul.sv
// rtl/fp16_mul_arbiter_mul.sv - shared combinational fp16 multiplier (truncating, flush-to-zero)
module fp16_mul
  import fp16_pkg::*;
(
  input  logic [FP16_W-1:0] i_a,
  input  logic [FP16_W-1:0] i_b,
  output logic [FP16_W-1:0] o_p
);

  logic                  w_sign;
  logic [FP16_EXP_W-1:0] w_ea;
  logic [FP16_EXP_W-1:0] w_eb;
  logic [FP16_MAN_W:0]   w_ma;
  logic [FP16_MAN_W:0]   w_mb;
  logic [21:0]           w_prod;
  logic [11:0]           w_prod_hi;
  logic [9:0]            w_unused_lo;
  logic signed [7:0]     w_exp;
  logic [FP16_MAN_W-1:0] w_man;

  // Multiply significands, normalise by at most one place, drop the low bits (no rounding)
  always_comb begin
    w_sign      = i_a[15] ^ i_b[15];
    w_ea        = i_a[14:10];
    w_eb        = i_b[14:10];
    w_ma        = {1'b1, i_a[9:0]};
    w_mb        = {1'b1, i_b[9:0]};
    w_prod      = {11'b0, w_ma} * {11'b0, w_mb};
    w_prod_hi   = w_prod[21:10];
    w_unused_lo = w_prod[9:0];
    w_exp       = {3'b000, w_ea} + {3'b000, w_eb} - 8'(FP16_BIAS) + {7'b0, w_prod_hi[11]};
    w_man       = w_prod_hi[11] ? w_prod_hi[10:1] : w_prod_hi[9:0];
    // Exponent field zero covers +/-0; subnormal inputs are treated the same way
    if (w_ea == '0 || w_eb == '0) begin
      o_p = FP16_ZERO;
    end else if (w_exp <= 8'sd0) begin
      o_p = FP16_ZERO;
    end else begin
      o_p = {w_sign, w_exp[4:0], w_man};
    end
  end

endmodule

// File: rtl/fp16_mul_arbiter_rr.sv
// rtl/fp16_mul_arbiter_rr.sv - round-robin grant: first request at or after the pointer, one-hot
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt
);

  logic            w_found;
  logic [ID_W-1:0] w_idx;

  // Scan requesters starting at the pointer, wrapping modulo NREQ, and grant the first one found
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = ID_W'((int'(i_ptr) + k) % NREQ);
      if (i_en && !w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// rtl/fp16_mul_arbiter.sv - round-robin share of one fp16 multiplier, 2-stage pipe; FP16_ARB_PERF_EN adds perf counters
module fp16_mul_arbiter
  import fp16_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
`ifdef FP16_ARB_PERF_EN
  output logic [31:0]         perf_acc_cnt,
  output logic [31:0]         perf_stall_cnt,
`endif
  fp16_mul_arbiter_if.slave   bus
);

  logic                 r_s0_v;
  op_beat_t             r_s0;
  logic                 r_s1_v;
  logic [FP16_W-1:0]    r_s1_data;
  logic [ID_W-1:0]      r_s1_id;
  logic [ID_W-1:0]      r_rr_ptr;

  logic                 w_s1_adv;
  logic                 w_s0_adv;
  logic                 w_arb_en;
  logic [NREQ-1:0]      w_gnt;
  logic                 w_acc;
  logic [ID_W-1:0]      w_acc_id;
  op_beat_t             w_acc_beat;
  logic [ID_W-1:0]      w_next_ptr;
  logic [FP16_W-1:0]    w_mul_p;
  logic [OP_ID_W-1:0]   w_unused_id;

  assign w_s1_adv    = !r_s1_v || bus.res_ready;
  assign w_s0_adv    = !r_s0_v || w_s1_adv;
  // No grant while in reset or flushing, so nothing is accepted in those cycles
  assign w_arb_en    = rst_n && !flush && w_s0_adv;
  assign w_acc       = |(bus.req_valid & w_gnt);
  assign w_next_ptr  = (w_acc_id == ID_W'(NREQ - 1)) ? '0 : w_acc_id + ID_W'(1);
  assign w_unused_id = r_s0.id;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .i_req (bus.req_valid),
    .i_ptr (r_rr_ptr),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt)
  );

  // Pick the granted requester's operands and encode its index
  always_comb begin
    w_acc_id   = '0;
    w_acc_beat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_acc_id     = ID_W'(i);
        w_acc_beat.a = bus.req_a[FP16_W*i +: FP16_W];
        w_acc_beat.b = bus.req_b[FP16_W*i +: FP16_W];
      end
    end
    w_acc_beat.id = OP_ID_W'(w_acc_id);
  end

  fp16_mul u_mul (
    .i_a (r_s0.a),
    .i_b (r_s0.b),
    .o_p (w_mul_p)
  );

  // Operand stage, result stage and round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s0_v    <= 1'b0;
      r_s0      <= '0;
      r_s1_v    <= 1'b0;
      r_s1_data <= FP16_ZERO;
      r_s1_id   <= '0;
      r_rr_ptr  <= '0;
    end else if (flush) begin
      r_s0_v <= 1'b0;
      r_s1_v <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_v <= r_s0_v;
        if (r_s0_v) begin
          r_s1_data <= w_mul_p;
          r_s1_id   <= r_s0.id[ID_W-1:0];
        end
      end
      if (w_s0_adv) begin
        r_s0_v <= w_acc;
        if (w_acc) begin
          r_s0 <= w_acc_beat;
        end
      end
      if (w_acc) begin
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  assign bus.req_ready = w_gnt;
  assign bus.res_valid = r_s1_v;
  assign bus.res_data  = r_s1_data;
  assign bus.res_id    = r_s1_id;

`ifdef FP16_ARB_PERF_EN
  logic [31:0] r_perf_acc_cnt;
  logic [31:0] r_perf_stall_cnt;

  // Count accepts and backpressured result cycles; only reset clears them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_acc_cnt   <= '0;
      r_perf_stall_cnt <= '0;
    end else begin
      if (w_acc) begin
        r_perf_acc_cnt <= r_perf_acc_cnt + 32'd1;
      end
      if (r_s1_v && !bus.res_ready) begin
        r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      end
    end
  end

  assign perf_acc_cnt   = r_perf_acc_cnt;
  assign perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// tb/tb_fp16_mul_arbiter.sv - directed self-checking bench for fp16_mul_arbiter
module tb_fp16_mul_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  fp16_mul_arbiter_if #(.NREQ(4)) bus ();

`ifdef FP16_ARB_PERF_EN
  logic [31:0] perf_acc_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fp16_mul_arbiter #(.NREQ(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
`ifdef FP16_ARB_PERF_EN
    .perf_acc_cnt   (perf_acc_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .bus            (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] t2_prod [4] = '{16'h4000, 16'h4400, 16'h4600, 16'h4800};
  logic [15:0] t4_a    [8] = '{16'h3E00, 16'hC000, 16'h8000, 16'h4000, 16'h0400, 16'h0400, 16'h8400, 16'h3C01};
  logic [15:0] t4_b    [8] = '{16'h4000, 16'h3800, 16'h4000, 16'h8000, 16'h3C00, 16'h3800, 16'h0400, 16'h3E00};
  logic [15:0] t4_p    [8] = '{16'h4200, 16'hBC00, 16'h0000, 16'h0000, 16'h0400, 16'h0000, 16'h0000, 16'h3E01};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[16*i +: 16] = a;
    bus.req_b[16*i +: 16] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 4'h0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;

    // Reset state, with all requesters asserting valid
    bus.req_valid = 4'hF;
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_data",  32'(bus.res_data),  0);
    chk("rst_res_id",    32'(bus.res_id),    0);

    // 1: single op from requester 0, latency
    rst_n = 1'b1;
    bus.req_valid = 4'b0001;
    set_op(0, 16'h3C00, 16'h4000);
    #1;
    chk("t1_ready", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    chk("t1_valid_t", 32'(bus.res_valid), 0);
    tick();
    chk("t1_valid_t1", 32'(bus.res_valid), 1);
    chk("t1_data",     32'(bus.res_data),  'h4000);
    chk("t1_id",       32'(bus.res_id),    0);
    tick();
    chk("t1_single", 32'(bus.res_valid), 0);

    // 2: all requesters valid, full throughput, grant order 0,1,2,3,0,1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_op(0, 16'h3C00, 16'h4000);
    set_op(1, 16'h4000, 16'h4000);
    set_op(2, 16'h4200, 16'h4000);
    set_op(3, 16'h4400, 16'h4000);
    bus.req_valid = 4'hF;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("t2_grant", 32'(bus.req_ready), 1 << (c % 4));
      chk("t2_valid", 32'(bus.res_valid), (c >= 2) ? 1 : 0);
      if (c >= 2) begin
        chk("t2_id",   32'(bus.res_id),   (c - 2) % 4);
        chk("t2_data", 32'(bus.res_data), 32'(t2_prod[(c - 2) % 4]));
      end
      tick();
    end

    // 3: backpressure on a full pipe (s1 = id0, s0 = id1)
    bus.res_ready = 1'b0;
    for (int h = 0; h < 5; h++) begin
      #1;
      chk("t3_ready", 32'(bus.req_ready), 0);
      chk("t3_valid", 32'(bus.res_valid), 1);
      chk("t3_data",  32'(bus.res_data),  'h4000);
      chk("t3_id",    32'(bus.res_id),    0);
      tick();
    end
    bus.res_ready = 1'b1;
    bus.req_valid = 4'h0;
    #1;
    chk("t3_rel_data0", 32'(bus.res_data), 'h4000);
    tick();
    chk("t3_rel_valid1", 32'(bus.res_valid), 1);
    chk("t3_rel_id1",    32'(bus.res_id),    1);
    chk("t3_rel_data1",  32'(bus.res_data),  'h4400);
    tick();
    chk("t3_rel_empty", 32'(bus.res_valid), 0);

    // 4: arithmetic vectors streamed through requester 2
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        bus.req_valid = 4'b0100;
        set_op(2, t4_a[c], t4_b[c]);
      end else begin
        bus.req_valid = 4'b0000;
      end
      #1;
      if (c < 8) chk("t4_grant", 32'(bus.req_ready), 4);
      chk("t4_valid", 32'(bus.res_valid), (c >= 2) ? 1 : 0);
      if (c >= 2) begin
        chk("t4_data", 32'(bus.res_data), 32'(t4_p[c - 2]));
        chk("t4_id",   32'(bus.res_id),   2);
      end
      tick();
    end

    // 5a: flush with two ops in flight; pointer sits at 3 here
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b0001;
    set_op(0, 16'h4000, 16'h4000);
    #1;
    chk("t5_grant0", 32'(bus.req_ready), 1);
    tick();
    chk("t5_grant1", 32'(bus.req_ready), 1);
    tick();
    chk("t5_full_valid", 32'(bus.res_valid), 1);
    chk("t5_full_ready", 32'(bus.req_ready), 0);
    bus.res_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("t5_flush_ready", 32'(bus.req_ready), 0);
    tick();
    flush = 1'b0;
    bus.req_valid = 4'h0;
    #1;
    chk("t5_post_valid", 32'(bus.res_valid), 0);
    tick();
    chk("t5_post_valid2", 32'(bus.res_valid), 0);
    tick();
    chk("t5_post_valid3", 32'(bus.res_valid), 0);
    bus.req_valid = 4'hF;
    #1;
    chk("t5_ptr_kept", 32'(bus.req_ready), 2);

    // 5b: reset mid-stream
    tick();
    tick();
    chk("t5_rst_pre_valid", 32'(bus.res_valid), 1);
    chk("t5_rst_pre_id",    32'(bus.res_id),    1);
    chk("t5_rst_pre_data",  32'(bus.res_data),  'h4400);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready_comb", 32'(bus.req_ready), 0);
    tick();
    chk("t5_rst_valid", 32'(bus.res_valid), 0);
    chk("t5_rst_data",  32'(bus.res_data),  0);
    chk("t5_rst_id",    32'(bus.res_id),    0);
    chk("t5_rst_ready", 32'(bus.req_ready), 0);
    rst_n = 1'b1;
    bus.req_valid = 4'h0;
    tick();
    tick();
    chk("t5_rst_no_result", 32'(bus.res_valid), 0);
    bus.req_valid = 4'hF;
    #1;
    chk("t5_rst_ptr", 32'(bus.req_ready), 1);
    bus.req_valid = 4'h0;

`ifdef FP16_ARB_PERF_EN
    // 6: performance counters
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_acc_rst",   perf_acc_cnt,   0);
    chk("t6_stall_rst", perf_stall_cnt, 0);
    bus.res_ready = 1'b1;
    bus.req_valid = 4'b0001;
    repeat (9) tick();
    bus.req_valid = 4'h0;
    tick();
    tick();
    tick();
    chk("t6_acc9",   perf_acc_cnt,   9);
    chk("t6_stall0", perf_stall_cnt, 0);
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'h0;
    tick();
    repeat (3) tick();
    bus.res_ready = 1'b1;
    #1;
    chk("t6_acc10",  perf_acc_cnt,   10);
    chk("t6_stall3", perf_stall_cnt, 3);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("t6_flush_acc",   perf_acc_cnt,   10);
    chk("t6_flush_stall", perf_stall_cnt, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
